// File: rtl/pipe_regfile.sv
// rtl/pipe_regfile.sv - architectural register file with WB bypass and pending-write scoreboard
//
// Purpose:
//   Integer register file that responds to the writeback request bus.
//   It has two combinational read ports for decode, and a write from WB
//   bypasses to those ports in the same cycle.
//   A per-register counter of in-flight writes lets decode detect RAW
//   hazards. Decode raises the count at issue and WB lowers it at commit.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_ni       asynchronous active-low reset
//   wb_req_i     packed {rd_wen, rd[4:0], rd_wdata[XLEN-1:0]} from WB, at most one commit per cycle
//   iss_valid_i  decode issues an instruction this cycle
//   iss_rd_wen_i the issued instruction writes a register
//   iss_rd_i     destination register of the issued instruction
//   iss_ready_o  issue accepted; low while the target counter is saturated
//   rs1_i/rs2_i  read addresses
//   rs1_rdata_o  read data, port 1 (combinational)
//   rs2_rdata_o  read data, port 2 (combinational)
//   rs1_busy_o   rs1 still has an uncommitted write pending
//   rs2_busy_o   rs2 still has an uncommitted write pending
//   wb_err_o     sticky flag: WB committed to a register with no pending write

module pipe_regfile #(
  parameter int NREG   = 32,
  parameter int XLEN   = 32,
  parameter int PEND_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [XLEN+5:0]   wb_req_i,
  input  logic              iss_valid_i,
  input  logic              iss_rd_wen_i,
  input  logic [4:0]        iss_rd_i,
  output logic              iss_ready_o,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic [XLEN-1:0]   rs1_rdata_o,
  output logic [XLEN-1:0]   rs2_rdata_o,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              wb_err_o
);

  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  // Unpacked view of the writeback request
  logic            wb_wen;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;

  assign wb_wen   = wb_req_i[XLEN+5];
  assign wb_rd    = wb_req_i[XLEN+4:XLEN];
  assign wb_wdata = wb_req_i[XLEN-1:0];

  logic [XLEN-1:0]   regs [NREG];
  logic [PEND_W-1:0] cnt  [NREG];
  logic              err_q;

  logic wb_commit;   // architectural write to a real register
  logic dec;         // that write also retires a pending entry
  logic iss_target;  // the issued instruction names a real destination
  logic inc;         // the issue is accepted and adds a pending entry
  logic same_reg;    // the issue and the commit hit the same register

  always_comb begin
    wb_commit  = 1'b0;
    dec        = 1'b0;
    iss_target = 1'b0;
    inc        = 1'b0;
    same_reg   = 1'b0;

    wb_commit  = wb_wen && (wb_rd != 5'd0);
    dec        = wb_commit && (cnt[wb_rd] != '0);
    iss_target = iss_rd_wen_i && (iss_rd_i != 5'd0);

    // A saturated register can still take an issue when a commit frees a
    // slot on that same register in this cycle.
    iss_ready_o = !(iss_target && (cnt[iss_rd_i] == CNT_MAX)
                    && !(dec && (wb_rd == iss_rd_i)));

    inc      = iss_valid_i && iss_target && iss_ready_o;
    same_reg = inc && dec && (iss_rd_i == wb_rd);
  end

  // Pending-write counters. When inc and dec hit the same register, they
  // cancel and the count stays the same. When they hit different
  // registers, the two writes below go to different entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
    end else if (!same_reg) begin
      if (inc) begin
        cnt[iss_rd_i] <= cnt[iss_rd_i] + 1'b1;
      end
      if (dec) begin
        cnt[wb_rd] <= cnt[wb_rd] - 1'b1;
      end
    end
  end

  // Register array. x0 is never written, so it stays at its reset value of 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else if (wb_commit) begin
      regs[wb_rd] <= wb_wdata;
    end
  end

  // A commit with nothing pending means WB and decode lost track of each
  // other. The data is still written, and the flag holds until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (wb_commit && (cnt[wb_rd] == '0)) begin
      err_q <= 1'b1;
    end
  end

  assign wb_err_o = err_q;

  // Read ports, with same-cycle bypass from WB
  always_comb begin
    rs1_rdata_o = regs[rs1_i];
    if (rs1_i == 5'd0) begin
      rs1_rdata_o = '0;
    end else if (wb_wen && (wb_rd == rs1_i)) begin
      rs1_rdata_o = wb_wdata;
    end
  end

  always_comb begin
    rs2_rdata_o = regs[rs2_i];
    if (rs2_i == 5'd0) begin
      rs2_rdata_o = '0;
    end else if (wb_wen && (wb_rd == rs2_i)) begin
      rs2_rdata_o = wb_wdata;
    end
  end

  // When the last pending write commits this cycle, the bypass already
  // supplies its data, so the source is not busy. An issue in this cycle
  // does not make a same-cycle read busy.
  assign rs1_busy_o = (rs1_i != 5'd0) && (cnt[rs1_i] != '0)
                      && !(dec && (wb_rd == rs1_i) && (cnt[rs1_i] == 1));
  assign rs2_busy_o = (rs2_i != 5'd0) && (cnt[rs2_i] != '0)
                      && !(dec && (wb_rd == rs2_i) && (cnt[rs2_i] == 1));

endmodule

// File: tb/tb_pipe_regfile.sv
// tb/tb_pipe_regfile.sv - scoreboard bench for pipe_regfile with a reference model
module tb_pipe_regfile;

  localparam int MAXP = 3;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        wb_wen = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_wdata = '0;
  logic        iss_valid_i = 1'b0;
  logic        iss_rd_wen_i = 1'b0;
  logic [4:0]  iss_rd_i = '0;
  logic        iss_ready_o;
  logic [4:0]  rs1_i = '0;
  logic [4:0]  rs2_i = '0;
  logic [31:0] rs1_rdata_o;
  logic [31:0] rs2_rdata_o;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        wb_err_o;

  pipe_regfile #(.NREG(32), .XLEN(32), .PEND_W(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wb_req_i    ({wb_wen, wb_rd, wb_wdata}),
    .iss_valid_i (iss_valid_i),
    .iss_rd_wen_i(iss_rd_wen_i),
    .iss_rd_i    (iss_rd_i),
    .iss_ready_o (iss_ready_o),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .rs1_rdata_o (rs1_rdata_o),
    .rs2_rdata_o (rs2_rdata_o),
    .rs1_busy_o  (rs1_busy_o),
    .rs2_busy_o  (rs2_busy_o),
    .wb_err_o    (wb_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    logic        rdy;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: register contents, in-flight write counts, error flag
  logic [31:0] ref_regs [32];
  int          ref_cnt  [32];
  bit          ref_err;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = '0;
      ref_cnt[i]  = 0;
    end
    ref_err = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic ww,
                                           input logic [4:0] wrd, input logic [31:0] wd);
    if (a == 0) return 32'h0;
    if (ww && wrd == a) return wd;
    return ref_regs[a];
  endfunction

  // Drive one cycle of stimulus, queue the expected outputs for it, then
  // advance the model to its state after the next rising edge.
  task automatic cycle(input logic v, input logic iw, input logic [4:0] ird,
                       input logic ww, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    int   retire1;
    int   retire2;
    int   retire_i;
    bit   commit;
    bit   rdy;
    @(negedge clk_i);
    iss_valid_i  = v;
    iss_rd_wen_i = iss_rd_wen_i;
    iss_rd_wen_i = iw;
    iss_rd_i     = ird;
    wb_wen       = ww;
    wb_rd        = wrd;
    wb_wdata     = wd;
    rs1_i        = a1;
    rs2_i        = a2;
    commit   = ww && (wrd != 0) && (ref_cnt[wrd] > 0);
    retire1  = (commit && wrd == a1) ? 1 : 0;
    retire2  = (commit && wrd == a2) ? 1 : 0;
    retire_i = (commit && wrd == ird) ? 1 : 0;
    rdy      = !(iw && ird != 0 && (ref_cnt[ird] - retire_i) >= MAXP);
    e.d1  = ref_read(a1, ww, wrd, wd);
    e.d2  = ref_read(a2, ww, wrd, wd);
    e.b1  = (a1 != 0) && ((ref_cnt[a1] - retire1) > 0);
    e.b2  = (a2 != 0) && ((ref_cnt[a2] - retire2) > 0);
    e.rdy = rdy;
    e.err = ref_err;
    exp_q.push_back(e);
    if (ww && wrd != 0) begin
      if (ref_cnt[wrd] == 0) ref_err = 1'b1;
      else ref_cnt[wrd]--;
      ref_regs[wrd] = wd;
    end
    if (v && iw && ird != 0 && rdy) ref_cnt[ird]++;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cycle(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, a1, a2);
  endtask

  // Assert reset in the middle of a cycle and check the outputs change at once
  task automatic mid_reset(input string tag);
    @(posedge clk_i);
    #2;
    wb_wen = 1'b0; iss_valid_i = 1'b1; iss_rd_wen_i = 1'b1; iss_rd_i = 5'd7;
    rs1_i = 5'd3; rs2_i = 5'd7;
    rst_ni = 1'b0;
    #1;
    chk({tag, "_rdata"}, rs1_rdata_o, 32'h0);
    chk({tag, "_busy1"}, {31'h0, rs1_busy_o}, 32'h0);
    chk({tag, "_busy2"}, {31'h0, rs2_busy_o}, 32'h0);
    chk({tag, "_ready"}, {31'h0, iss_ready_o}, 32'h1);
    chk({tag, "_err"}, {31'h0, wb_err_o}, 32'h0);
    model_reset();
    iss_valid_i = 1'b0; iss_rd_wen_i = 1'b0;
    @(posedge clk_i);
    #2;
    rst_ni = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the DUT outputs,
  // well clear of the rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rs1_rdata", rs1_rdata_o, e.d1);
        chk("rs2_rdata", rs2_rdata_o, e.d2);
        chk("rs1_busy", {31'h0, rs1_busy_o}, {31'h0, e.b1});
        chk("rs2_busy", {31'h0, rs2_busy_o}, {31'h0, e.b2});
        chk("iss_ready", {31'h0, iss_ready_o}, {31'h0, e.rdy});
        chk("wb_err", {31'h0, wb_err_o}, {31'h0, e.err});
      end
    end
  end

  initial begin
    int pend[$];
    logic [4:0] wrd;
    model_reset();
    repeat (2) @(posedge clk_i);
    #2 rst_ni = 1'b1;

    idle(5'd0, 5'd5);
    // x0 is never written and never busy
    cycle(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);
    // RAW on x5, resolved by the bypass on the commit cycle
    cycle(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'h1234, 5'd5, 5'd5);
    idle(5'd5, 5'd0);
    // Saturate x7, then a commit and an issue in the same cycle
    repeat (3) cycle(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    cycle(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    cycle(1'b1, 1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
    cycle(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    // Issue and commit on x9 in the same cycle leave the count unchanged
    cycle(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    cycle(1'b1, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    idle(5'd9, 5'd0);
    // Spurious commit to x3 still writes the data and sets the sticky error
    cycle(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hCAFE0003, 5'd0, 5'd0);
    idle(5'd3, 5'd0);
    idle(5'd3, 5'd7);
    mid_reset("rst1");
    idle(5'd3, 5'd7);

    // Randomized traffic over x0..x11
    for (int n = 0; n < 3000; n++) begin
      pend.delete();
      for (int r = 1; r < 12; r++) if (ref_cnt[r] > 0) pend.push_back(r);
      if (pend.size() > 0 && $urandom_range(99) < 85)
        wrd = 5'(pend[$urandom_range(pend.size() - 1)]);
      else
        wrd = 5'($urandom_range(11));
      cycle($urandom_range(1) == 1, $urandom_range(4) != 0, 5'($urandom_range(11)),
            $urandom_range(9) < 6, wrd, $urandom,
            ($urandom_range(3) == 0) ? wrd : 5'($urandom_range(11)),
            5'($urandom_range(11)));
      if (n == 1500) mid_reset("rst2");
    end

    idle(5'd0, 5'd0);
    repeat (3) @(negedge clk_i);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
